sa_pe_multi: RTL and testbench
==============================

// Module: sa_pe_multi
// PURPOSE
//  Next-generation systolic-array processing element. Holds a bank of WEIGHT_DEPTH
//  stationary weights, selectable per cycle. Supports weight-stationary (WS) and
//  output-stationary (OS) dataflows plus an accumulator drain chain. Valid-qualified
//  datapath; tiles into an R x C grid, act flows east, weight/psum flows south.
// PARAMETERS
//  MUL_DATAWIDTH  8   signed act/weight width
//  ADD_DATAWIDTH  32  signed psum/acc width; must be >= 2*MUL_DATAWIDTH (elab $error otherwise)
//  WEIGHT_DEPTH   4   weights held per PE, >=1; WSEL_W = max(1,$clog2(WEIGHT_DEPTH)) (localparam)
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       async active-low reset
//  i_mode         in   2       pe_mode_e: 00 PRELOAD, 01 WS, 10 OS, 11 DRAIN
//  i_valid        in   1       qualifies i_act/i_weight/i_psum this cycle
//  i_act          in   MUL     activation from west
//  i_weight       in   MUL     weight from north (PRELOAD, OS)
//  i_psum         in   ADD     psum from north (WS, DRAIN); tie 0 on top row
//  i_wsel         in   WSEL_W  bank entry used in WS
//  i_clear        in   1       clear OS accumulator
//  o_valid        out  1       registered i_valid (DRAIN: 1 every cycle)
//  o_act          out  MUL     act to east
//  o_weight_psum  out  ADD     weight (sign-extended) / psum / drained acc to south
// BEHAVIOUR
//  - clk and rst_n: one clock; reset is asynchronous and active-low.
//  - Reset: o_valid=0, o_act=0, o_weight_psum=0, acc_r=0, bank all 0, wr_ptr=0.
//  - All outputs registered: latency 1 cycle in every mode. prod = signed i_act * weight,
//    sign-extended to ADD width. Signed 2's complement throughout.
//  - !i_valid (non-DRAIN): o_valid<=0; o_act, o_weight_psum, acc_r, bank, wr_ptr hold.
//  - PRELOAD & i_valid: bank[wr_ptr]<=i_weight; wr_ptr wraps DEPTH-1->0 (overwrites oldest);
//    o_weight_psum<=sext(i_weight); o_act holds.
//  - wr_ptr<=0 every cycle i_mode!=PRELOAD (a new preload burst always starts at entry 0).
//  - WS & i_valid: o_weight_psum<=i_psum+i_act*bank[i_wsel]; o_act<=i_act.
//    i_wsel>=WEIGHT_DEPTH: product uses 0.
//  - OS & i_valid: acc_r<=acc_r+i_act*i_weight; o_act<=i_act; o_weight_psum<=sext(i_weight).
//    i_clear same cycle: acc_r<=prod (clear, then accumulate). i_clear without valid: acc_r<=0.
//    i_clear ignored outside OS.
//  - DRAIN (every cycle, i_valid ignored): o_weight_psum<=acc_r; acc_r<=i_psum; o_valid<=1.
//    A column of R PEs emits all R accumulators bottom-first in R cycles.
//  - Mode may change on any cycle; new mode takes effect on that same edge; no pipeline
//    flush. Reset mid-operation discards bank and acc.
//  - Overflow: wraps modulo 2^ADD_DATAWIDTH (see CONFIGURATION).
// CONFIGURATION
//  SA_PE_SAT_EN defined: WS and OS adds saturate to [-2^(ADD-1), 2^(ADD-1)-1];
//    sticky internal flag sat_r sets on any clip, cleared by reset or i_clear.
//  SA_PE_SAT_EN undefined: plain wrap-around add, no sat_r logic.
// STRUCTURE
//  sa_pkg: typedef enum logic[1:0] pe_mode_e {PE_PRELOAD,PE_WS,PE_OS,PE_DRAIN};
//    shared sat_add function (used under SA_PE_SAT_EN).
//  Sub-module sa_mac_acc: combinational signed mult + add, optional saturation,
//    shared by WS (addend i_psum) and OS (addend acc_r or 0).
// TESTING  (MUL=8, ADD=32, DEPTH=4)
//  1 Reset mid-OS (acc=500) -> all outputs 0, acc 0; then DRAIN -> emits 0.
//  2 PRELOAD 5 valids w=1,2,3,4,9 -> bank={9,2,3,4}; o_weight_psum tracks each w at +1 cycle.
//  3 WS, wsel=2, act=-3, psum=10, valid -> next cycle o_weight_psum=1, o_act=-3, o_valid=1;
//    valid=0 next -> o_valid=0, outputs hold.
//  4 OS acts 2,3,-1 x weights 4,5,6 -> acc=17; i_clear+valid act=7 w=2 -> acc=14.
//  5 DRAIN with acc=14, i_psum=99,0 -> o_weight_psum=14 then 99, o_valid=1 both cycles.
//  6 SA_PE_SAT_EN: WS psum=0x7FFFFFF0, act=127, w=127 -> 0x7FFFFFFF; without macro -> wraps.

Source files
------------

// File: rtl/sa_pkg.sv
// Package for the sa_pe_multi processing element.
// Contents:
//   pe_mode_e - 2-bit operating mode (PRELOAD, WS, OS, DRAIN)
//   sat_res_t - result of a saturating add (clip flag + value)
//   sat_add   - signed add clipped to a w-bit two's complement range;
//               used by sa_mac_acc when SA_PE_SAT_EN is defined
package sa_pkg;

    typedef enum logic [1:0] {
        PE_PRELOAD = 2'b00,
        PE_WS      = 2'b01,
        PE_OS      = 2'b10,
        PE_DRAIN   = 2'b11
    } pe_mode_e;

    // Widest accumulator the saturating helper handles exactly
    // (the 64-bit intermediate sum cannot itself overflow below this).
    localparam int SAT_MAX_W = 63;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] sum;
    } sat_res_t;

    // a and b must already be sign-extended w-bit values; the exact sum
    // is clipped to [-2^(w-1), 2^(w-1)-1] and the clip is flagged.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int unsigned        w);
        logic signed [63:0] full_s;
        logic signed [63:0] hi_s;
        logic signed [63:0] lo_s;
        sat_res_t           res;
        full_s = a + b;
        hi_s   = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        lo_s   = -hi_s - 64'sd1;
        if (full_s > hi_s) begin
            res.sat = 1'b1;
            res.sum = hi_s;
        end else if (full_s < lo_s) begin
            res.sat = 1'b1;
            res.sum = lo_s;
        end else begin
            res.sat = 1'b0;
            res.sum = full_s;
        end
        return res;
    endfunction

endpackage

// File: rtl/sa_mac_acc.sv
// Combinational signed multiply-accumulate shared by the WS and OS paths.
//   sum = addend + sext(act * weight)
// Configuration macro: SA_PE_SAT_EN - when defined the add saturates to the
// ADD_DATAWIDTH signed range and 'sat' reports a clip; otherwise the add
// wraps and the 'sat' port does not exist.
// Ports:
//   act    in  MUL_DATAWIDTH  signed activation
//   weight in  MUL_DATAWIDTH  signed weight
//   addend in  ADD_DATAWIDTH  signed psum / accumulator
//   sum    out ADD_DATAWIDTH  signed result
//   sat    out 1              clip indicator (SA_PE_SAT_EN only)
module sa_mac_acc #(
    parameter int MUL_DATAWIDTH = 8,
    parameter int ADD_DATAWIDTH = 32
) (
    input  logic signed [MUL_DATAWIDTH-1:0] act,
    input  logic signed [MUL_DATAWIDTH-1:0] weight,
    input  logic signed [ADD_DATAWIDTH-1:0] addend,
`ifdef SA_PE_SAT_EN
    output logic                            sat,
`endif
    output logic signed [ADD_DATAWIDTH-1:0] sum
);
    import sa_pkg::*;

    localparam int PROD_W = 2 * MUL_DATAWIDTH;

    logic signed [PROD_W-1:0]        prod_s;
    logic signed [ADD_DATAWIDTH-1:0] prod_ext_s;

    // Operands are widened first so the product is full precision.
    assign prod_s     = PROD_W'(act) * PROD_W'(weight);
    assign prod_ext_s = ADD_DATAWIDTH'(prod_s);

`ifdef SA_PE_SAT_EN
    sat_res_t res_s;

    if (ADD_DATAWIDTH > SAT_MAX_W) begin : g_sat_width_err
        $error("sa_mac_acc: ADD_DATAWIDTH too wide for saturating add");
    end

    // Saturating add of the widened product onto the addend.
    always_comb begin
        res_s = sat_add(64'(addend), 64'(prod_ext_s), ADD_DATAWIDTH);
    end

    assign sum = res_s.sum[ADD_DATAWIDTH-1:0];
    assign sat = res_s.sat;
`else
    assign sum = addend + prod_ext_s;
`endif

endmodule

// File: rtl/sa_pe_multi.sv
// Systolic-array processing element with a bank of WEIGHT_DEPTH stationary
// weights. Modes: PRELOAD (fill bank), WS (weight-stationary MAC onto the
// incoming psum), OS (output-stationary local accumulation), DRAIN (shift
// accumulators south). Every output is registered (latency 1).
// Configuration macro: SA_PE_SAT_EN - saturating WS/OS adds plus a sticky
// internal clip flag sat_r; undefined gives wrap-around adds.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   i_mode         pe_mode_e
//   i_valid        qualifies i_act/i_weight/i_psum (ignored in DRAIN)
//   i_act          activation from west
//   i_weight       weight from north (PRELOAD, OS)
//   i_psum         psum from north (WS, DRAIN)
//   i_wsel         bank entry used in WS
//   i_clear        clear OS accumulator
//   o_valid        registered valid (1 every DRAIN cycle)
//   o_act          activation to east
//   o_weight_psum  sext weight / psum / drained accumulator to south
module sa_pe_multi
    import sa_pkg::*;
#(
    parameter  int MUL_DATAWIDTH = 8,
    parameter  int ADD_DATAWIDTH = 32,
    parameter  int WEIGHT_DEPTH  = 4,
    localparam int WSEL_W        = (WEIGHT_DEPTH > 1) ? $clog2(WEIGHT_DEPTH) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [1:0]                      i_mode,
    input  logic                            i_valid,
    input  logic signed [MUL_DATAWIDTH-1:0] i_act,
    input  logic signed [MUL_DATAWIDTH-1:0] i_weight,
    input  logic signed [ADD_DATAWIDTH-1:0] i_psum,
    input  logic [WSEL_W-1:0]               i_wsel,
    input  logic                            i_clear,
    output logic                            o_valid,
    output logic signed [MUL_DATAWIDTH-1:0] o_act,
    output logic signed [ADD_DATAWIDTH-1:0] o_weight_psum
);

    if (ADD_DATAWIDTH < 2 * MUL_DATAWIDTH) begin : g_width_err
        $error("sa_pe_multi: ADD_DATAWIDTH must be >= 2*MUL_DATAWIDTH");
    end
    if (WEIGHT_DEPTH < 1) begin : g_depth_err
        $error("sa_pe_multi: WEIGHT_DEPTH must be >= 1");
    end

    pe_mode_e                        mode_s;
    logic signed [MUL_DATAWIDTH-1:0] bank_r [WEIGHT_DEPTH];
    logic [WSEL_W-1:0]               wr_ptr_r;
    logic [WSEL_W-1:0]               wr_ptr_nxt_s;
    logic signed [ADD_DATAWIDTH-1:0] acc_r;
    logic signed [MUL_DATAWIDTH-1:0] bank_sel_s;
    logic signed [MUL_DATAWIDTH-1:0] mac_weight_s;
    logic signed [ADD_DATAWIDTH-1:0] mac_addend_s;
    logic signed [ADD_DATAWIDTH-1:0] mac_sum_s;
    logic signed [ADD_DATAWIDTH-1:0] weight_ext_s;

    assign mode_s       = pe_mode_e'(i_mode);
    assign weight_ext_s = ADD_DATAWIDTH'(i_weight);

    // Bank read; an i_wsel with no matching entry yields weight 0.
    always_comb begin
        bank_sel_s = '0;
        for (int i = 0; i < WEIGHT_DEPTH; i++) begin
            bank_sel_s = (i_wsel == WSEL_W'(i)) ? bank_r[i] : bank_sel_s;
        end
    end

    // Preload write pointer advance, wrapping onto the oldest entry.
    always_comb begin
        if (wr_ptr_r == WSEL_W'(WEIGHT_DEPTH - 1)) begin
            wr_ptr_nxt_s = '0;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + WSEL_W'(1);
        end
    end

    // MAC operand select: WS adds onto the incoming psum, OS onto the
    // accumulator (or onto 0 when clearing, giving clear-then-accumulate).
    always_comb begin
        mac_weight_s = '0;
        mac_addend_s = '0;
        case (mode_s)
            PE_WS: begin
                mac_weight_s = bank_sel_s;
                mac_addend_s = i_psum;
            end
            PE_OS: begin
                mac_weight_s = i_weight;
                mac_addend_s = i_clear ? '0 : acc_r;
            end
            default: begin
                mac_weight_s = '0;
                mac_addend_s = '0;
            end
        endcase
    end

`ifdef SA_PE_SAT_EN
    logic mac_sat_s;
    logic sat_r;
`endif

    sa_mac_acc #(
        .MUL_DATAWIDTH (MUL_DATAWIDTH),
        .ADD_DATAWIDTH (ADD_DATAWIDTH)
    ) u_mac (
        .act    (i_act),
        .weight (mac_weight_s),
        .addend (mac_addend_s),
`ifdef SA_PE_SAT_EN
        .sat    (mac_sat_s),
`endif
        .sum    (mac_sum_s)
    );

    // Weight bank storage, written only by valid PRELOAD cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WEIGHT_DEPTH; i++) begin
                bank_r[i] <= '0;
            end
        end else if (mode_s == PE_PRELOAD && i_valid) begin
            bank_r[wr_ptr_r] <= i_weight;
        end
    end

    // Output registers, accumulator and preload pointer per mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid       <= 1'b0;
            o_act         <= '0;
            o_weight_psum <= '0;
            acc_r         <= '0;
            wr_ptr_r      <= '0;
        end else begin
            case (mode_s)
                PE_PRELOAD: begin
                    o_valid <= i_valid;
                    if (i_valid) begin
                        wr_ptr_r      <= wr_ptr_nxt_s;
                        o_weight_psum <= weight_ext_s;
                    end
                end
                PE_WS: begin
                    wr_ptr_r <= '0;
                    o_valid  <= i_valid;
                    if (i_valid) begin
                        o_weight_psum <= mac_sum_s;
                        o_act         <= i_act;
                    end
                end
                PE_OS: begin
                    wr_ptr_r <= '0;
                    o_valid  <= i_valid;
                    if (i_valid) begin
                        acc_r         <= mac_sum_s;
                        o_act         <= i_act;
                        o_weight_psum <= weight_ext_s;
                    end else if (i_clear) begin
                        acc_r <= '0;
                    end
                end
                PE_DRAIN: begin
                    // Each PE hands its accumulator south and takes the one
                    // from above, so a column empties bottom-first.
                    wr_ptr_r      <= '0;
                    o_valid       <= 1'b1;
                    o_weight_psum <= acc_r;
                    acc_r         <= i_psum;
                end
                default: begin
                    wr_ptr_r <= '0;
                    o_valid  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SA_PE_SAT_EN
    // Sticky clip flag: set by any clipped WS/OS add, cleared by i_clear in OS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_r <= 1'b0;
        end else if (mode_s == PE_OS && i_clear) begin
            sat_r <= 1'b0;
        end else if ((mode_s == PE_WS || mode_s == PE_OS) && i_valid && mac_sat_s) begin
            sat_r <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sa_pe_multi.sv
// Self-checking bench for sa_pe_multi (MUL=8, ADD=32, DEPTH=4): a table of
// directed vectors covering PRELOAD/WS/OS/DRAIN, followed by hand-written
// sequences for reset mid-accumulation and add overflow.
module tb_sa_pe_multi;
    import sa_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [1:0]         i_mode = 2'b00;
    logic               i_valid = 1'b0;
    logic signed [7:0]  i_act = 8'sd0;
    logic signed [7:0]  i_weight = 8'sd0;
    logic signed [31:0] i_psum = 32'sd0;
    logic [1:0]         i_wsel = 2'd0;
    logic               i_clear = 1'b0;
    logic               o_valid;
    logic signed [7:0]  o_act;
    logic signed [31:0] o_weight_psum;

    int n_tests = 0;
    int n_fail  = 0;

    sa_pe_multi #(
        .MUL_DATAWIDTH (8),
        .ADD_DATAWIDTH (32),
        .WEIGHT_DEPTH  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_mode        (i_mode),
        .i_valid       (i_valid),
        .i_act         (i_act),
        .i_weight      (i_weight),
        .i_psum        (i_psum),
        .i_wsel        (i_wsel),
        .i_clear       (i_clear),
        .o_valid       (o_valid),
        .o_act         (o_act),
        .o_weight_psum (o_weight_psum)
    );

    always #5 clk = ~clk;

    typedef struct {
        pe_mode_e           mode;
        logic               valid;
        logic signed [7:0]  act;
        logic signed [7:0]  w;
        logic signed [31:0] psum;
        logic [1:0]         wsel;
        logic               clear;
        logic               e_valid;
        logic               chk_act;
        logic signed [7:0]  e_act;
        logic signed [31:0] e_wp;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(input pe_mode_e m, input logic v, input int a, input int wt,
                                input int ps, input int ws, input logic cl, input logic ev,
                                input logic ca, input int ea, input int ewp);
        vec_t r;
        r.mode = m;       r.valid = v;      r.act = 8'(a);    r.w = 8'(wt);
        r.psum = 32'(ps); r.wsel = 2'(ws);  r.clear = cl;     r.e_valid = ev;
        r.chk_act = ca;   r.e_act = 8'(ea); r.e_wp = 32'(ewp);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input pe_mode_e m, input logic v, input int a, input int wt,
                         input int ps, input int ws, input logic cl);
        i_mode = m; i_valid = v; i_act = 8'(a); i_weight = 8'(wt);
        i_psum = 32'(ps); i_wsel = 2'(ws); i_clear = cl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             mode       v  act  w   psum  ws clr ev ca  eact  ewp
        vecs[0]  = mk(PE_PRELOAD, 1,  0,  1,    0, 0, 0, 1, 1,  0,    1);
        vecs[1]  = mk(PE_PRELOAD, 1,  0,  2,    0, 0, 0, 1, 1,  0,    2);
        vecs[2]  = mk(PE_PRELOAD, 1,  0,  3,    0, 0, 0, 1, 1,  0,    3);
        vecs[3]  = mk(PE_PRELOAD, 1,  0,  4,    0, 0, 0, 1, 1,  0,    4);
        vecs[4]  = mk(PE_PRELOAD, 1,  0,  9,    0, 0, 0, 1, 1,  0,    9);
        vecs[5]  = mk(PE_WS,      1,  1,  0,    0, 0, 0, 1, 1,  1,    9);
        vecs[6]  = mk(PE_WS,      1,  1,  0,    0, 1, 0, 1, 1,  1,    2);
        vecs[7]  = mk(PE_WS,      1,  1,  0,    0, 3, 0, 1, 1,  1,    4);
        vecs[8]  = mk(PE_WS,      1, -3,  0,   10, 2, 0, 1, 1, -3,    1);
        vecs[9]  = mk(PE_WS,      0,  5,  0,   77, 2, 0, 0, 1, -3,    1);
        vecs[10] = mk(PE_WS,      1,  2,  0, -100, 2, 0, 1, 1,  2,  -94);
        vecs[11] = mk(PE_PRELOAD, 0,  0, 55,    0, 0, 0, 0, 1,  2,  -94);
        vecs[12] = mk(PE_PRELOAD, 1,  9,  7,    0, 0, 0, 1, 1,  2,    7);
        vecs[13] = mk(PE_WS,      1,  1,  0,    0, 0, 0, 1, 1,  1,    7);
        vecs[14] = mk(PE_WS,      1, -1,  0,    5, 1, 0, 1, 1, -1,    3);
        vecs[15] = mk(PE_OS,      1,  2,  4,    0, 0, 0, 1, 1,  2,    4);
        vecs[16] = mk(PE_OS,      1,  3,  5,    0, 0, 0, 1, 1,  3,    5);
        vecs[17] = mk(PE_OS,      1, -1,  6,    0, 0, 0, 1, 1, -1,    6);
        vecs[18] = mk(PE_OS,      0,  8,  8,    0, 0, 0, 0, 1, -1,    6);
        vecs[19] = mk(PE_DRAIN,   0,  0,  0, 1000, 0, 0, 1, 0,  0,   17);
        vecs[20] = mk(PE_OS,      1,  7,  2,    0, 0, 1, 1, 1,  7,    2);
        vecs[21] = mk(PE_DRAIN,   0,  0,  0,   99, 0, 0, 1, 0,  0,   14);
        vecs[22] = mk(PE_DRAIN,   1,  0,  0,    0, 0, 0, 1, 0,  0,   99);
        vecs[23] = mk(PE_DRAIN,   0,  0,  0,  300, 0, 0, 1, 0,  0,    0);
        vecs[24] = mk(PE_WS,      1,  1,  0,    0, 0, 1, 1, 1,  1,    7);
        vecs[25] = mk(PE_OS,      1,  1,  1,    0, 0, 0, 1, 1,  1,    1);
        vecs[26] = mk(PE_DRAIN,   0,  0,  0,   50, 0, 0, 1, 0,  0,  301);
        vecs[27] = mk(PE_OS,      0,  0,  0,    0, 0, 1, 0, 0,  0,  301);
        vecs[28] = mk(PE_DRAIN,   0,  0,  0,    0, 0, 0, 1, 0,  0,    0);

        // Reset state
        #1 rst_n = 1'b0;
        #11;
        check("reset o_valid", 32'(o_valid), 32'd0);
        check("reset o_act", 32'(o_act), 32'd0);
        check("reset o_weight_psum", o_weight_psum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].mode, vecs[i].valid, int'(vecs[i].act), int'(vecs[i].w),
                  int'(vecs[i].psum), int'(vecs[i].wsel), vecs[i].clear);
            tick();
            check($sformatf("v%0d o_valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d o_weight_psum", i), o_weight_psum, vecs[i].e_wp);
            if (vecs[i].chk_act) begin
                check($sformatf("v%0d o_act", i), 32'(o_act), 32'(vecs[i].e_act));
            end
        end

        // Reset in the middle of OS accumulation (acc = 500)
        drive(PE_OS, 1'b1, 10, 50, 0, 0, 1'b0);
        tick();
        check("os acc500 o_weight_psum", o_weight_psum, 32'd50);
        drive(PE_OS, 1'b0, 0, 0, 0, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst o_valid", 32'(o_valid), 32'd0);
        check("midrst o_act", 32'(o_act), 32'd0);
        check("midrst o_weight_psum", o_weight_psum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(PE_DRAIN, 1'b0, 0, 0, 0, 0, 1'b0);
        tick();
        check("post-rst drain o_weight_psum", o_weight_psum, 32'd0);
        check("post-rst drain o_valid", 32'(o_valid), 32'd1);
        drive(PE_WS, 1'b1, 1, 0, 0, 0, 1'b0);
        tick();
        check("post-rst bank0 cleared", o_weight_psum, 32'd0);

        // Overflow at the top and bottom of the 32-bit range
        drive(PE_PRELOAD, 1'b1, 0, 127, 0, 0, 1'b0);
        tick();
        check("preload 127", o_weight_psum, 32'd127);
        drive(PE_WS, 1'b1, 127, 0, 32'h7FFF_FFF0, 0, 1'b0);
        tick();
`ifdef SA_PE_SAT_EN
        check("ws pos overflow", o_weight_psum, 32'h7FFF_FFFF);
`else
        check("ws pos overflow", o_weight_psum, 32'h8000_3EF1);
`endif
        drive(PE_WS, 1'b1, -128, 0, 32'h8000_0000, 0, 1'b0);
        tick();
`ifdef SA_PE_SAT_EN
        check("ws neg overflow", o_weight_psum, 32'h8000_0000);
`else
        check("ws neg overflow", o_weight_psum, 32'h7FFF_C080);
`endif
        check("ws overflow o_act", 32'(o_act), 32'hFFFF_FF80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
